// File: rtl/subneg_mem_responder_pkg.sv
// rtl/subneg_mem_responder_pkg.sv - shared FSM states, default geometry and address decode helper
package subneg_mem_responder_pkg;

  // Bus-cycle state of the responder
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int         DEFAULT_DEPTH     = 32;
  localparam logic [7:0] DEFAULT_DISP_ADDR = 8'h15;

  // True when an 8-bit bus address falls inside the implemented memory
  function automatic logic addr_in_mem(input logic [7:0] addr, input int depth);
    return int'({24'd0, addr}) < depth;
  endfunction

endpackage

// File: rtl/subneg_mem_array.sv
// rtl/subneg_mem_array.sv - DEPTH x 8 storage, one write port, async read, async clear
module subneg_mem_array #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Storage: whole array clears on reset, otherwise one byte per enabled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/subneg_mem_responder.sv
// rtl/subneg_mem_responder.sv - strobe-driven memory/display responder for the SUBNEG CPU bus
module subneg_mem_responder
  import subneg_mem_responder_pkg::*;
#(
  parameter int         DEPTH     = DEFAULT_DEPTH,
  parameter logic [7:0] DISP_ADDR = DEFAULT_DISP_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       le,
  input  logic       moe,
  input  logic       mwe,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic       load_valid,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [7:0] display,
  output logic       bus_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] display_q, display_d;
  logic       bus_err_q, bus_err_d;
  logic       le_q, moe_q, mwe_q;

  logic          conflict;
  logic          rd_start;
  logic          wr_start;
  logic          bus_wr;
  logic          load_wr;
  logic          any_wr;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic [7:0]    rdata;

  // A strobe level only starts a new cycle if it was low on the previous edge,
  // or if the previous edge was an address cycle that ignored it. This keeps
  // one access per pulse, including pulses that began inside a conflict.
  assign conflict = ~le & moe & mwe;
  assign rd_start = moe & ~mwe & (~moe_q | le_q);
  assign wr_start = mwe & ~moe & (~mwe_q | le_q);

  // Next-state, address and error decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bus_err_d = bus_err_q;
    bus_wr    = 1'b0;
    if (le) begin
      state_d = ST_ADDR;
      addr_d  = bus_in;
    end else if (conflict) begin
      state_d   = ST_IDLE;
      bus_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ADDR: begin
          if (rd_start) begin
            state_d = ST_READ;
          end else if (wr_start) begin
            state_d = ST_WRITE;
            bus_wr  = 1'b1;
          end
        end
        ST_READ: begin
          if (!moe) begin
            state_d = ST_IDLE;
            addr_d  = addr_q + 8'd1;
          end
        end
        ST_WRITE: begin
          if (!mwe) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Program loads only slip in when the CPU bus is quiet between cycles
  assign load_ready = ~(le | moe | mwe) & ((state_q == ST_IDLE) | (state_q == ST_ADDR));
  assign load_wr    = load_valid & load_ready;

  // The CPU write and the load port never coincide, so they share one write path
  assign any_wr  = bus_wr | load_wr;
  assign wr_addr = bus_wr ? addr_q : load_addr;
  assign wr_data = bus_wr ? bus_in : load_data;

  // The display register shadows memory at its address for both reads and writes
  assign mem_we    = any_wr & (wr_addr != DISP_ADDR) & addr_in_mem(wr_addr, DEPTH);
  assign display_d = (any_wr && (wr_addr == DISP_ADDR)) ? wr_data : display_q;

  // State, address, display, error and strobe-sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'h00;
      display_q <= 8'h00;
      bus_err_q <= 1'b0;
      le_q      <= 1'b0;
      moe_q     <= 1'b0;
      mwe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      display_q <= display_d;
      bus_err_q <= bus_err_d;
      le_q      <= le;
      moe_q     <= moe;
      mwe_q     <= mwe;
    end
  end

  subneg_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (wr_addr[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (addr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Read decode: display register, then memory, unmapped addresses read as zero
  always_comb begin
    rdata = 8'h00;
    if (addr_q == DISP_ADDR) begin
      rdata = display_q;
    end else if (addr_in_mem(addr_q, DEPTH)) begin
      rdata = mem_rdata;
    end
  end

  // The bus is driven only from registered READ state, so reset releases it at once
  assign bus_oe  = (state_q == ST_READ);
  assign bus_out = bus_oe ? rdata : 8'h00;
  assign display = display_q;
  assign bus_err = bus_err_q;

endmodule
